// File: rtl/thumb_prefetch_unit.sv
// rtl/thumb_prefetch_unit.sv - Thumb-1 word fetch, halfword prefetch queue and redirect control
//
// Purpose:
//   Fetches 32-bit words from the memory bus, splits each into 16-bit Thumb
//   instructions, and holds them in a QDEPTH-halfword queue. Decode consumes
//   the queue head on a valid/ready stream tagged with its byte PC. A redirect
//   flushes the queue and restarts fetching at a new target.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   redirect_valid   one-cycle flush request; redirect_pc is the new target (bit 0 ignored)
//   insn_valid/ready head-of-queue handshake; insn/insn_pc are the head halfword and its address
//   q_count          halfwords currently queued
//   mem_valid/ready  read request handshake; mem_addr is word aligned, mem_rdata valid on ready
module thumb_prefetch_unit #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        insn_valid,
  input  logic                        insn_ready,
  output logic [15:0]                 insn,
  output logic [31:0]                 insn_pc,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                        mem_valid,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ready,
  input  logic [31:0]                 mem_rdata
);

  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam int          PW       = $clog2(QDEPTH);
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic [31:0]   addr_q;
  logic [31:0]   redir_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_nx;
  logic [15:0]   queue [QDEPTH];

  logic          issue;
  logic [31:0]   issue_addr;
  logic          push;
  logic          pop;
  logic          has_room;
  logic [CW-1:0] push_n;

  // Masking (rather than slicing) keeps every redirect_pc bit referenced.
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFE;

  // A request is only issued with room for a full word, and the count cannot
  // grow while it is outstanding, so the response can always be enqueued.
  assign has_room  = (count <= CW'(QDEPTH - 2));
  assign pop       = insn_valid && insn_ready;
  assign wr_ptr_nx = wr_ptr + PW'(1);

  // A fetch from an odd halfword address only yields the upper halfword.
  assign push_n    = push ? (fetch_pc[1] ? CW'(1) : CW'(2)) : '0;

  assign insn_valid = (count != '0);
  assign insn       = queue[rd_ptr];
  assign insn_pc    = head_pc;
  assign q_count    = count;
  assign mem_addr   = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_valid  = 1'b0;
    issue      = 1'b0;
    issue_addr = {fetch_pc[31:2], 2'b00};
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          state_next = REQ;
          issue      = 1'b1;
          issue_addr = {redir_pc[31:2], 2'b00};
        end else if (has_room) begin
          state_next = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          if (redirect_valid) begin
            // Response belongs to the old stream; reissue at the target immediately.
            state_next = REQ;
            issue      = 1'b1;
            issue_addr = {redir_pc[31:2], 2'b00};
          end else begin
            state_next = IDLE;
            push       = 1'b1;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn; wait it out and drop its data.
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_next = REQ;
          issue      = 1'b1;
          // fetch_pc already holds the latest target; a redirect landing on
          // this same edge supersedes it.
          issue_addr = redirect_valid ? {redir_pc[31:2], 2'b00}
                                      : {fetch_pc[31:2], 2'b00};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      head_pc  <= START_PC;
      addr_q   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        queue[i] <= '0;
      end
    end else begin
      if (issue) begin
        addr_q <= issue_addr;
      end
      if (redirect_valid) begin
        // fetch_pc doubles as the drain target, so a redirect during DRAIN
        // simply overwrites it.
        fetch_pc <= redir_pc;
        head_pc  <= redir_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          if (fetch_pc[1]) begin
            queue[wr_ptr] <= mem_rdata[31:16];
            wr_ptr        <= wr_ptr + PW'(1);
            fetch_pc      <= fetch_pc + 32'd2;
          end else begin
            queue[wr_ptr]    <= mem_rdata[15:0];
            queue[wr_ptr_nx] <= mem_rdata[31:16];
            wr_ptr           <= wr_ptr + PW'(2);
            fetch_pc         <= fetch_pc + 32'd4;
          end
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          head_pc <= head_pc + 32'd2;
        end
        count <= count + push_n - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_thumb_prefetch_unit.sv
// tb/tb_thumb_prefetch_unit.sv - directed vector bench for thumb_prefetch_unit
module tb_thumb_prefetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst_b_n;

  logic        a_redir, a_iv, a_irdy, a_mv, a_mrdy;
  logic [31:0] a_rpc, a_ipc, a_ma, a_rdata;
  logic [15:0] a_insn;
  logic [2:0]  a_qc;

  logic        b_redir, b_iv, b_irdy, b_mv, b_mrdy;
  logic [31:0] b_rpc, b_ipc, b_ma, b_rdata;
  logic [15:0] b_insn;
  logic [2:0]  b_qc;

  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    case (pc)
      32'h0:   return 16'h2003;
      32'h2:   return 16'h2105;
      default: return pc[15:0] ^ 16'hC3A5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {hw_at(a + 32'd2), hw_at(a)};
  endfunction

  assign a_rdata = mem_word(a_ma);
  assign b_rdata = mem_word(b_ma);

  thumb_prefetch_unit #(.QDEPTH(4), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(a_redir), .redirect_pc(a_rpc),
    .insn_valid(a_iv), .insn_ready(a_irdy), .insn(a_insn), .insn_pc(a_ipc),
    .q_count(a_qc),
    .mem_valid(a_mv), .mem_addr(a_ma), .mem_ready(a_mrdy), .mem_rdata(a_rdata)
  );

  thumb_prefetch_unit #(.QDEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .redirect_valid(b_redir), .redirect_pc(b_rpc),
    .insn_valid(b_iv), .insn_ready(b_irdy), .insn(b_insn), .insn_pc(b_ipc),
    .q_count(b_qc),
    .mem_valid(b_mv), .mem_addr(b_ma), .mem_ready(b_mrdy), .mem_rdata(b_rdata)
  );

  typedef struct {
    logic        mrdy;
    logic        irdy;
    logic        redir;
    logic [31:0] rpc;
    logic        iv;
    logic [15:0] insn;
    logic [31:0] ipc;
    logic [2:0]  qc;
    logic        mv;
    logic [31:0] ma;
  } vec_t;

  localparam int NA = 36;
  localparam int NB = 5;
  vec_t va [NA];
  vec_t vb [NB];

  function automatic vec_t mk(input logic mrdy, input logic irdy, input logic redir,
                              input logic [31:0] rpc, input logic iv, input logic [15:0] insn,
                              input logic [31:0] ipc, input logic [2:0] qc, input logic mv,
                              input logic [31:0] ma);
    vec_t v;
    v.mrdy = mrdy; v.irdy = irdy; v.redir = redir; v.rpc = rpc;
    v.iv = iv; v.insn = insn; v.ipc = ipc; v.qc = qc; v.mv = mv; v.ma = ma;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_row(input string tag, input int idx, input vec_t v, input logic iv,
                         input logic [15:0] ins, input logic [31:0] ipc,
                         input logic [2:0] qc, input logic mv, input logic [31:0] ma);
    chk({tag, ".insn_valid"}, idx, {31'd0, iv}, {31'd0, v.iv});
    if (v.iv) chk({tag, ".insn"}, idx, {16'd0, ins}, {16'd0, v.insn});
    chk({tag, ".insn_pc"}, idx, ipc, v.ipc);
    chk({tag, ".q_count"}, idx, {29'd0, qc}, {29'd0, v.qc});
    chk({tag, ".mem_valid"}, idx, {31'd0, mv}, {31'd0, v.mv});
    chk({tag, ".mem_addr"}, idx, ma, v.ma);
  endtask

  initial begin
    int   fetches;
    logic prev_stall;
    logic [31:0] prev_addr;

    // reset, word0, backpressure fill, pop/refill
    va[0]  = mk(1,0,0,32'h0,   0,16'h0000,32'h0,   0,0,32'h0);
    va[1]  = mk(1,0,0,32'h0,   0,16'h0000,32'h0,   0,1,32'h0);
    va[2]  = mk(1,0,0,32'h0,   1,16'h2003,32'h0,   2,0,32'h0);
    va[3]  = mk(1,0,0,32'h0,   1,16'h2003,32'h0,   2,1,32'h4);
    va[4]  = mk(1,0,0,32'h0,   1,16'h2003,32'h0,   4,0,32'h4);
    va[5]  = mk(1,1,0,32'h0,   1,16'h2003,32'h0,   4,0,32'h4);
    va[6]  = mk(1,1,0,32'h0,   1,16'h2105,32'h2,   3,0,32'h4);
    va[7]  = mk(1,0,0,32'h0,   1,16'hC3A1,32'h4,   2,0,32'h4);
    va[8]  = mk(1,0,0,32'h0,   1,16'hC3A1,32'h4,   2,1,32'h8);
    va[9]  = mk(1,0,0,32'h0,   1,16'hC3A1,32'h4,   4,0,32'h8);
    // redirect to odd halfword 0x106
    va[10] = mk(1,0,1,32'h106, 1,16'hC3A1,32'h4,   4,0,32'h8);
    va[11] = mk(1,0,0,32'h0,   0,16'h0000,32'h106, 0,1,32'h104);
    va[12] = mk(1,0,0,32'h0,   1,16'hC2A3,32'h106, 1,0,32'h104);
    va[13] = mk(1,1,0,32'h0,   1,16'hC2A3,32'h106, 1,1,32'h108);
    va[14] = mk(1,0,0,32'h0,   1,16'hC2AD,32'h108, 2,0,32'h108);
    va[15] = mk(1,0,0,32'h0,   1,16'hC2AD,32'h108, 2,1,32'h10C);
    // redirect plus pop with q_count=3 (target bit 0 set)
    va[16] = mk(1,1,0,32'h0,   1,16'hC2AD,32'h108, 4,0,32'h10C);
    va[17] = mk(1,1,1,32'h201, 1,16'hC2AF,32'h10A, 3,0,32'h10C);
    va[18] = mk(1,0,0,32'h0,   0,16'h0000,32'h200, 0,1,32'h200);
    va[19] = mk(1,0,0,32'h0,   1,16'hC1A5,32'h200, 2,0,32'h200);
    // redirect during a three-cycle stall -> drain
    va[20] = mk(0,0,0,32'h0,   1,16'hC1A5,32'h200, 2,1,32'h204);
    va[21] = mk(0,0,0,32'h0,   1,16'hC1A5,32'h200, 2,1,32'h204);
    va[22] = mk(0,0,1,32'h300, 1,16'hC1A5,32'h200, 2,1,32'h204);
    va[23] = mk(0,0,0,32'h0,   0,16'h0000,32'h300, 0,1,32'h204);
    va[24] = mk(1,0,0,32'h0,   0,16'h0000,32'h300, 0,1,32'h204);
    va[25] = mk(1,0,0,32'h0,   0,16'h0000,32'h300, 0,1,32'h300);
    va[26] = mk(1,0,0,32'h0,   1,16'hC0A5,32'h300, 2,0,32'h300);
    // redirect coinciding with a completing response
    va[27] = mk(1,0,1,32'h400, 1,16'hC0A5,32'h300, 2,1,32'h304);
    va[28] = mk(1,0,0,32'h0,   0,16'h0000,32'h400, 0,1,32'h400);
    va[29] = mk(1,0,0,32'h0,   1,16'hC7A5,32'h400, 2,0,32'h400);
    // two redirects while draining, latest wins
    va[30] = mk(0,0,0,32'h0,   1,16'hC7A5,32'h400, 2,1,32'h404);
    va[31] = mk(0,0,1,32'h500, 1,16'hC7A5,32'h400, 2,1,32'h404);
    va[32] = mk(0,0,1,32'h602, 0,16'h0000,32'h500, 0,1,32'h404);
    va[33] = mk(1,0,0,32'h0,   0,16'h0000,32'h602, 0,1,32'h404);
    va[34] = mk(1,0,0,32'h0,   0,16'h0000,32'h602, 0,1,32'h600);
    va[35] = mk(1,0,0,32'h0,   1,16'hC5A7,32'h602, 1,0,32'h600);

    // address wrap from RESET_PC=0xFFFFFFFC, free-running
    vb[0] = mk(1,1,0,32'h0, 0,16'h0000,32'hFFFF_FFFC, 0,0,32'h0);
    vb[1] = mk(1,1,0,32'h0, 0,16'h0000,32'hFFFF_FFFC, 0,1,32'hFFFF_FFFC);
    vb[2] = mk(1,1,0,32'h0, 1,16'h3C59,32'hFFFF_FFFC, 2,0,32'hFFFF_FFFC);
    vb[3] = mk(1,1,0,32'h0, 1,16'h3C5B,32'hFFFF_FFFE, 1,1,32'h0);
    vb[4] = mk(1,1,0,32'h0, 1,16'h2003,32'h0,         2,0,32'h0);

    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    a_redir = 1'b0; a_rpc = '0; a_irdy = 1'b0; a_mrdy = 1'b0;
    b_redir = 1'b0; b_rpc = '0; b_irdy = 1'b0; b_mrdy = 1'b0;
    fetches    = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NA; i++) begin
      a_mrdy  = va[i].mrdy;
      a_irdy  = va[i].irdy;
      a_redir = va[i].redir;
      a_rpc   = va[i].rpc;
      @(negedge clk);
      chk_row("a", i, va[i], a_iv, a_insn, a_ipc, a_qc, a_mv, a_ma);
      if (prev_stall) begin
        chk("bus_hold.mem_valid", i, {31'd0, a_mv}, 32'd1);
        chk("bus_hold.mem_addr", i, a_ma, prev_addr);
      end
      prev_stall = a_mv && !a_mrdy;
      prev_addr  = a_ma;
      if (a_mv && a_mrdy) fetches++;
      if (i == 5) chk("fetches_while_stalled", i, fetches, 32'd2);
      if (i == 9) chk("fetches_after_refill", i, fetches, 32'd3);
      @(posedge clk);
      #1;
    end

    // reset while a request is stalled drops request and queue
    a_mrdy  = 1'b0;
    a_irdy  = 1'b0;
    a_redir = 1'b0;
    @(negedge clk);
    chk("pre_reset.mem_valid", 0, {31'd0, a_mv}, 32'd1);
    chk("pre_reset.mem_addr", 0, a_ma, 32'h604);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset.mem_valid", 0, {31'd0, a_mv}, 32'd0);
    chk("mid_reset.q_count", 0, {29'd0, a_qc}, 32'd0);
    chk("mid_reset.insn_valid", 0, {31'd0, a_iv}, 32'd0);
    chk("mid_reset.mem_addr", 0, a_ma, 32'h0);
    chk("mid_reset.insn_pc", 0, a_ipc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    #1 rst_b_n = 1'b1;
    for (int i = 0; i < NB; i++) begin
      b_mrdy  = vb[i].mrdy;
      b_irdy  = vb[i].irdy;
      b_redir = vb[i].redir;
      b_rpc   = vb[i].rpc;
      @(negedge clk);
      chk_row("b", i, vb[i], b_iv, b_insn, b_ipc, b_qc, b_mv, b_ma);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
